// File: rtl/iob2axil_sync.sv
// ---------------------------------------------------------------------------
// iob2axil_sync
//
// Registered IOb-slave to AXI4-Lite-master bridge. It accepts one IOb request
// at a time, drives AW/W or AR from registers, tracks the AW and W handshakes
// independently, and waits for the B or R response before it accepts the next
// request. A non-OKAY response sets a sticky error flag.
//
// Ports
//   clk_i, cke_i, rst_n_i        clock, clock enable (freezes all state when
//                                low, reset included), sync active-low reset
//   iob_avalid_i/addr/wdata/wstrb IOb request; wstrb==0 selects a read
//   iob_ready_o                  high only while idle; request taken when
//                                avalid and ready are both high
//   iob_rvalid_o, iob_rdata_o    one-cycle read completion pulse, read data
//                                (held between reads)
//   err_o, err_clr_i             sticky response error flag and its clear
//   axil_aw*/w*/b*               AXI-Lite write address, data, response
//   axil_ar*/r*                  AXI-Lite read address and data
// ---------------------------------------------------------------------------
module iob2axil_sync #(
  parameter int         AXIL_ADDR_W = 32,
  parameter int         AXIL_DATA_W = 32,
  parameter int         ADDR_W      = AXIL_ADDR_W,
  parameter int         DATA_W      = AXIL_DATA_W,
  parameter logic [2:0] AXIL_PROT   = 3'd2
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     rst_n_i,
  // IOb slave
  input  logic                     iob_avalid_i,
  input  logic [ADDR_W-1:0]        iob_addr_i,
  input  logic [DATA_W-1:0]        iob_wdata_i,
  input  logic [DATA_W/8-1:0]      iob_wstrb_i,
  output logic                     iob_rvalid_o,
  output logic [DATA_W-1:0]        iob_rdata_o,
  output logic                     iob_ready_o,
  // error flag
  output logic                     err_o,
  input  logic                     err_clr_i,
  // AXI-Lite write address
  output logic                     axil_awvalid_o,
  input  logic                     axil_awready_i,
  output logic [AXIL_ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]               axil_awprot_o,
  // AXI-Lite write data
  output logic                     axil_wvalid_o,
  input  logic                     axil_wready_i,
  output logic [AXIL_DATA_W-1:0]   axil_wdata_o,
  output logic [AXIL_DATA_W/8-1:0] axil_wstrb_o,
  // AXI-Lite write response
  input  logic                     axil_bvalid_i,
  output logic                     axil_bready_o,
  input  logic [1:0]               axil_bresp_i,
  // AXI-Lite read address
  output logic                     axil_arvalid_o,
  input  logic                     axil_arready_i,
  output logic [AXIL_ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]               axil_arprot_o,
  // AXI-Lite read data
  input  logic                     axil_rvalid_i,
  output logic                     axil_rready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]               axil_rresp_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA
  } state_t;

  state_t                   r_state;
  logic                     r_ready;
  logic                     r_awvalid;
  logic                     r_wvalid;
  logic                     r_bready;
  logic                     r_arvalid;
  logic                     r_rready;
  logic                     r_rvalid;
  logic                     r_err;
  logic [AXIL_ADDR_W-1:0]   r_addr;
  logic [AXIL_DATA_W-1:0]   r_wdata;
  logic [AXIL_DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]        r_rdata;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_left;
  logic w_w_left;
  logic w_b_hs;
  logic w_r_hs;
  logic w_err_set;

  assign w_aw_hs   = r_awvalid & axil_awready_i;
  assign w_w_hs    = r_wvalid  & axil_wready_i;
  // A channel is still outstanding after this edge if its valid is up and
  // the slave has not taken it this cycle.
  assign w_aw_left = r_awvalid & ~axil_awready_i;
  assign w_w_left  = r_wvalid  & ~axil_wready_i;
  // bready/rready are only raised in the response states, so early
  // responses from the slave never count.
  assign w_b_hs    = r_bready & axil_bvalid_i;
  assign w_r_hs    = r_rready & axil_rvalid_i;
  assign w_err_set = (w_b_hs & (|axil_bresp_i)) | (w_r_hs & (|axil_rresp_i));

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        r_state   <= S_IDLE;
        r_ready   <= 1'b1;
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_bready  <= 1'b0;
        r_arvalid <= 1'b0;
        r_rready  <= 1'b0;
        r_rvalid  <= 1'b0;
        r_err     <= 1'b0;
        r_addr    <= '0;
        r_wdata   <= '0;
        r_wstrb   <= '0;
        r_rdata   <= '0;
      end else begin
        r_rvalid <= 1'b0;
        // A new error wins over a simultaneous clear.
        r_err    <= w_err_set | (r_err & ~err_clr_i);

        case (r_state)
          S_IDLE: begin
            if (iob_avalid_i) begin
              r_addr  <= AXIL_ADDR_W'(iob_addr_i);
              r_wdata <= iob_wdata_i;
              r_wstrb <= iob_wstrb_i;
              r_ready <= 1'b0;
              if (|iob_wstrb_i) begin
                r_state   <= S_WADDR;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
              end else begin
                r_state   <= S_RADDR;
                r_arvalid <= 1'b1;
              end
            end
          end

          S_WADDR: begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
            // Covers handshakes in either order or in the same cycle.
            if (!w_aw_left && !w_w_left) begin
              r_state  <= S_WRESP;
              r_bready <= 1'b1;
            end
          end

          S_WRESP: begin
            if (axil_bvalid_i) begin
              r_bready <= 1'b0;
              r_ready  <= 1'b1;
              r_state  <= S_IDLE;
            end
          end

          S_RADDR: begin
            if (axil_arready_i) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= S_RDATA;
            end
          end

          S_RDATA: begin
            if (axil_rvalid_i) begin
              r_rready <= 1'b0;
              r_rdata  <= axil_rdata_i;
              r_rvalid <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= S_IDLE;
            end
          end

          default: begin
            r_state   <= S_IDLE;
            r_ready   <= 1'b1;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign iob_ready_o    = r_ready;
  assign iob_rvalid_o   = r_rvalid;
  assign iob_rdata_o    = r_rdata;
  assign err_o          = r_err;

  assign axil_awvalid_o = r_awvalid;
  assign axil_awaddr_o  = r_addr;
  assign axil_awprot_o  = AXIL_PROT;
  assign axil_wvalid_o  = r_wvalid;
  assign axil_wdata_o   = r_wdata;
  assign axil_wstrb_o   = r_wstrb;
  assign axil_bready_o  = r_bready;

  assign axil_arvalid_o = r_arvalid;
  assign axil_araddr_o  = r_addr;
  assign axil_arprot_o  = AXIL_PROT;
  assign axil_rready_o  = r_rready;

endmodule
